rx_bit_packer: RTL and testbench
================================

RX_BIT_PACKER -- requirements
Module: rx_bit_packer

Interface
REQ-001 SHALL have parameter raw_symbol_length_g, default 128: output bits per OFDM symbol; must be a multiple of 8.
REQ-002 SHALL have parameter fifo_depth_g, default 8: output FIFO depth in bytes; power of two, at least 2.
REQ-003 SHALL have port sys_clk, input, 1: the single clock; all registers update on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sys_init, input, 1: synchronous resync/flush pulse from the RX control.
REQ-006 SHALL have port rx_rcv_data, input, 2: demapped dibit; bit 1 is the earlier bit.
REQ-007 SHALL have port rx_rcv_data_valid, input, 1: rx_rcv_data is valid this cycle; no back-pressure.
REQ-008 SHALL have port byte_data, output, 8: packed byte at the FIFO head.
REQ-009 SHALL have port byte_valid, output, 1: byte_data holds a valid byte.
REQ-010 SHALL have port byte_ready, input, 1: consumer accepts the byte.
REQ-011 SHALL have port byte_last, output, 1: the head byte is the last byte of an OFDM symbol.
REQ-012 SHALL have port fifo_level, output, clog2(fifo_depth_g)+1: number of bytes stored.
REQ-013 SHALL have port overflow, output, 1: sticky flag set when a byte is lost.

Function
REQ-014 SHALL shift each accepted dibit into a byte assembler MSB-first; the first dibit goes to byte bits 7:6 and the fourth to bits 1:0.
REQ-015 SHALL count accepted bits in a symbol counter, 0..raw_symbol_length_g-1, incrementing by 2 per dibit and wrapping to 0 after the final dibit of a symbol.
REQ-016 SHALL complete a byte at the edge where the 4th dibit is sampled and push it into the FIFO at that same edge.
REQ-017 SHALL tag a byte with last=1 when its 4th dibit is the final dibit of a symbol; last is stored alongside the byte in the FIFO.
REQ-018 SHALL drive byte_valid = (fifo_level != 0), with byte_data and byte_last taken from the head entry; latency is 1 cycle from the 4th dibit edge to byte_valid when the FIFO is empty.
REQ-019 SHALL pop the head entry on each edge where byte_valid=1 and byte_ready=1.
REQ-020 SHALL hold byte_data and byte_last stable while byte_valid=1 and byte_ready=0.
REQ-021 SHALL allow a simultaneous push and pop at any level: fifo_level is unchanged, and a full FIFO accepts the push.
REQ-022 SHALL, when a byte completes with the FIFO full and no pop that cycle, drop the byte, set overflow to 1, and keep the assembler and symbol counter advancing normally.
REQ-023 SHALL wrap the FIFO read and write pointers modulo fifo_depth_g.
REQ-024 SHALL have byte_ready ignored while byte_valid=0, with no pop and no level change.
REQ-025 SHALL, on sys_init=1, at that edge clear the assembler, symbol counter, FIFO pointers, fifo_level and overflow, and discard any dibit valid in the same cycle.
REQ-026 SHALL have sys_init take priority over push and pop in the same cycle.

Reset
REQ-027 SHALL, while sys_rst=1, asynchronously force byte_valid=0, byte_last=0, byte_data=0x00, fifo_level=0 and overflow=0, and clear the assembler, symbol counter and pointers.
REQ-028 SHALL have reset asserted mid-byte or mid-symbol discard the partial data, so the first dibit after release starts a new byte and a new symbol.

Verification
REQ-029 Dibits 3,0,2,1 with byte_ready=1 -> byte_data=0xC9 with byte_valid high for exactly one cycle, 1 cycle after the 4th dibit; byte_last=0.
REQ-030 With raw_symbol_length_g=128, 64 dibits -> 16 bytes; byte_last=1 only on the 16th byte; the next 64 dibits repeat the pattern.
REQ-031 With byte_ready=0 and 8 bytes pushed -> fifo_level=8 and overflow=0; a 9th byte -> overflow=1 and level stays 8; then byte_ready=1 -> the first 8 bytes are drained in order.
REQ-032 With FIFO full and a 4th dibit coinciding with a pop -> the new byte is stored, level stays 8, and overflow stays 0.
REQ-033 After 2 dibits, sys_init together with a valid dibit -> level=0 and overflow=0; the next 4 dibits 1,1,1,1 -> byte 0x55.
REQ-034 sys_rst pulse asserted while the FIFO holds 3 bytes and 1 dibit is pending -> all outputs are 0 immediately; after release, 4 dibits produce one fresh byte.

Source files
------------

// File: rtl/rx_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : rx_bit_packer
// Purpose  : Packs demapped dibits MSB-first into bytes, tags the last byte of
//            each OFDM symbol and buffers them in a small ready/valid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rx_bit_packer #(
    parameter int raw_symbol_length_g = 128,
    parameter int fifo_depth_g        = 8
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              sys_init,
    input  logic [1:0]                        rx_rcv_data,
    input  logic                              rx_rcv_data_valid,
    output logic [7:0]                        byte_data,
    output logic                              byte_valid,
    input  logic                              byte_ready,
    output logic                              byte_last,
    output logic [$clog2(fifo_depth_g):0]     fifo_level,
    output logic                              overflow
);

    localparam int              c_PW       = $clog2(fifo_depth_g);
    localparam int              c_SW       = $clog2(raw_symbol_length_g);
    localparam logic [c_SW-1:0] c_SYM_LAST = c_SW'(raw_symbol_length_g - 2);
    localparam logic [c_SW-1:0] c_SYM_STEP = c_SW'(2);
    localparam logic [c_PW:0]   c_FULL     = (c_PW + 1)'(fifo_depth_g);
    localparam logic [c_PW:0]   c_LVL_ONE  = (c_PW + 1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);

    logic [5:0]      r_asm;
    logic [1:0]      r_dcnt;
    logic [c_SW-1:0] r_sym;
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW:0]   r_level;
    logic            r_ovf;
    logic [8:0]      r_mem [fifo_depth_g];

    logic            w_accept;
    logic            w_done;
    logic            w_sym_end;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [7:0]      w_byte;

    assign w_accept  = rx_rcv_data_valid && !sys_init;
    assign w_done    = w_accept && (r_dcnt == 2'd3);
    assign w_sym_end = w_accept && (r_sym == c_SYM_LAST);
    assign w_full    = (r_level == c_FULL);
    assign w_pop     = (r_level != '0) && byte_ready && !sys_init;
    // A full FIFO still takes the new byte when the head leaves at the same edge.
    assign w_push    = w_done && (!w_full || w_pop);
    assign w_drop    = w_done && w_full && !w_pop;
    assign w_byte    = {r_asm, rx_rcv_data};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_asm   <= '0;
            r_dcnt  <= '0;
            r_sym   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (sys_init) begin
            r_asm   <= '0;
            r_dcnt  <= '0;
            r_sym   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm  <= w_byte[5:0];
                r_dcnt <= r_dcnt + 2'd1;
                r_sym  <= w_sym_end ? '0 : r_sym + c_SYM_STEP;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - c_LVL_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_sym_end, w_byte};
        end
    end

    // Head is masked when empty so stale storage never reaches the outputs.
    assign byte_valid = (r_level != '0);
    assign byte_data  = byte_valid ? r_mem[r_rptr][7:0] : 8'h00;
    assign byte_last  = byte_valid && r_mem[r_rptr][8];
    assign fifo_level = r_level;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rx_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_bit_packer
// Purpose  : Self-checking bench for rx_bit_packer (table, directed, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_bit_packer;

    localparam int c_L     = 128;
    localparam int c_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic [1:0] din = 2'd0;
    logic       dval = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] bdata;
    logic       bvalid;
    logic       blast;
    logic [3:0] level;
    logic       ovf;

    always #5 clk = ~clk;

    rx_bit_packer #(
        .raw_symbol_length_g (c_L),
        .fifo_depth_g        (c_DEPTH)
    ) dut (
        .sys_clk           (clk),
        .sys_rst           (rst),
        .sys_init          (init),
        .rx_rcv_data       (din),
        .rx_rcv_data_valid (dval),
        .byte_data         (bdata),
        .byte_valid        (bvalid),
        .byte_ready        (rdy),
        .byte_last         (blast),
        .fifo_level        (level),
        .overflow          (ovf)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } ent_t;

    typedef struct {
        bit       init;
        bit       v;
        bit [1:0] d;
        bit       rdy;
        bit       ev;
        bit [7:0] ed;
        bit       el;
        int       elvl;
        bit       eovf;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;

    ent_t m_q[$];
    int   m_acc = 0;
    int   m_nb  = 0;
    int   m_sym = 0;
    bit   m_ovf = 1'b0;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_acc = 0;
        m_nb  = 0;
        m_sym = 0;
        m_ovf = 1'b0;
    endtask

    // Byte-level reference: bits accumulate as an integer, symbol position counted in bits.
    task automatic model_step(input bit i_init, input bit v, input bit [1:0] d, input bit r);
        ent_t e;
        bit   pop;
        if (i_init) begin
            model_clear();
            return;
        end
        pop = (m_q.size() != 0) && r;
        if (pop) e = m_q.pop_front();
        if (v) begin
            m_acc = (m_acc * 4 + int'(d)) % 256;
            m_nb  += 2;
            m_sym += 2;
            if (m_nb == 8) begin
                e.d  = 8'(m_acc);
                e.l  = (m_sym == c_L);
                m_nb = 0;
                if (m_q.size() < c_DEPTH) m_q.push_back(e);
                else m_ovf = 1'b1;
            end
            if (m_sym == c_L) m_sym = 0;
        end
    endtask

    task automatic tick(input bit i_init, input bit v, input bit [1:0] d, input bit r);
        init = i_init;
        dval = v;
        din  = d;
        rdy  = r;
        @(posedge clk);
        model_step(i_init, v, d, r);
        #1;
    endtask

    task automatic model_cmp();
        chk("valid", 32'(bvalid), 32'(m_q.size() != 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        if (m_q.size() != 0) begin
            chk("data", 32'(bdata), 32'(m_q[0].d));
            chk("last", 32'(blast), 32'(m_q[0].l));
        end
    endtask

    function automatic vec_t mk(bit i, bit v, bit [1:0] d, bit r, bit ev, bit [7:0] ed,
                                bit el, int elvl, bit eovf);
        vec_t t;
        t.init = i; t.v = v; t.d = d; t.rdy = r;
        t.ev = ev; t.ed = ed; t.el = el; t.elvl = elvl; t.eovf = eovf;
        return t;
    endfunction

    initial begin
        int nbytes;
        int nlast;
        // single byte 3,0,2,1 -> 0xC9, one-cycle valid
        tbl.push_back(mk(0, 1, 2'd3, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd2, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 1, 1, 8'hC9, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'd0, 1, 0, 8'h00, 0, 0, 0));
        // two dibits, then init with a valid dibit, then 1,1,1,1 -> 0x55
        tbl.push_back(mk(0, 1, 2'd2, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd3, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2'd3, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'd1, 0, 1, 8'h55, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 0, 1, 8'h55, 0, 1, 0));
        tbl.push_back(mk(0, 0, 2'd0, 1, 0, 8'h00, 0, 0, 0));

        // reset state
        #3;
        chk("rst_valid", 32'(bvalid), 0);
        chk("rst_data", 32'(bdata), 0);
        chk("rst_last", 32'(blast), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        foreach (tbl[k]) begin
            tick(tbl[k].init, tbl[k].v, tbl[k].d, tbl[k].rdy);
            chk($sformatf("tbl%0d_valid", k), 32'(bvalid), 32'(tbl[k].ev));
            chk($sformatf("tbl%0d_level", k), 32'(level), 32'(tbl[k].elvl));
            chk($sformatf("tbl%0d_ovf", k), 32'(ovf), 32'(tbl[k].eovf));
            if (tbl[k].ev) begin
                chk($sformatf("tbl%0d_data", k), 32'(bdata), 32'(tbl[k].ed));
                chk($sformatf("tbl%0d_last", k), 32'(blast), 32'(tbl[k].el));
            end
        end

        // two full symbols streamed: last only on every 16th byte
        tick(1, 0, 2'd0, 1);
        nbytes = 0;
        nlast  = 0;
        for (int i = 0; i < 2 * c_L / 2 + 1; i++) begin
            tick(0, i < c_L, 2'($urandom_range(0, 3)), 1);
            model_cmp();
            if (bvalid) begin
                if (blast) nlast++;
                chk("sym_last_pos", 32'(blast), 32'(nbytes % 16 == 15));
                nbytes++;
            end
        end
        chk("sym_bytes", 32'(nbytes), 32);
        chk("sym_lasts", 32'(nlast), 2);

        // fill with no consumer, ninth byte overflows, then drain in order
        tick(1, 0, 2'd0, 0);
        for (int i = 0; i < 36; i++) begin
            tick(0, 1, 2'($urandom_range(0, 3)), 0);
            model_cmp();
            if (i == 31) begin
                chk("full_level", 32'(level), 8);
                chk("full_ovf", 32'(ovf), 0);
            end
        end
        chk("ovf_level", 32'(level), 8);
        chk("ovf_flag", 32'(ovf), 1);
        for (int i = 0; i < 9; i++) begin
            tick(0, 0, 2'd0, 1);
            model_cmp();
        end

        // full FIFO: byte completing together with a pop is kept
        tick(1, 0, 2'd0, 0);
        for (int i = 0; i < 35; i++) begin
            tick(0, 1, 2'($urandom_range(0, 3)), 0);
            model_cmp();
        end
        tick(0, 1, 2'd2, 1);
        model_cmp();
        chk("pp_level", 32'(level), 8);
        chk("pp_ovf", 32'(ovf), 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 2'd0, 1);
            model_cmp();
        end

        // asynchronous reset with 3 bytes stored and one dibit pending
        tick(1, 0, 2'd0, 0);
        for (int i = 0; i < 13; i++) tick(0, 1, 2'($urandom_range(0, 3)), 0);
        chk("pre_rst_level", 32'(level), 3);
        dval = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bvalid), 0);
        chk("arst_data", 32'(bdata), 0);
        chk("arst_last", 32'(blast), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_ovf", 32'(ovf), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick(0, 1, 2'd2, 0);
        chk("post_rst_level", 32'(level), 1);
        chk("post_rst_data", 32'(bdata), 32'h0AA);
        model_cmp();

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 2'($urandom_range(0, 3)), $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 2));
            model_cmp();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
